// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store controller: size encodings, FSM
// states, wait counter width and the little-endian lane helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] access_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Pull the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  sz,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Replace the addressed lane of a word with right-justified store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                               input logic [15:0] d,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  sz);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = d[7:0];
        end else if (lane[1]) begin
            r[31:16] = d;
        end else begin
            r[15:0] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane alignment: load extraction/extension from the word
// read back from memory, and sub-word store merge into that same word.
module lsu_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    assign load_data = lane_extract(rword, lane, size, sign_ext);
    assign merged    = lane_merge(rword, wdata, lane, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller between the core and a byte-addressed data memory.
// One request at a time; sub-word stores are done as read-modify-write.
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to flag accesses that
// run past MEM_BYTES as errors; otherwise the address is passed through.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int MEM_BYTES   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               write_q;
    logic [1:0]         size_q;
    logic [1:0]         lane_q;
    logic               sign_q;
    logic [15:0]        wdata_q;

    logic [2:0]         nbytes;
    logic [32:0]        end_addr;
    logic               misalign;
    logic               oob;
    logic               req_err;
    logic               accept;
    logic [31:0]        load_data;
    logic [31:0]        merged;

    assign accept = req_valid && req_ready;

    // Classify the incoming request: reserved size, misalignment, bounds.
    always_comb begin
        nbytes   = access_bytes(req_size);
        end_addr = {1'b0, req_addr} + {30'b0, nbytes};
        misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        oob      = end_addr > 33'(MEM_BYTES);
        req_err  = (req_size == SZ_RSVD) || misalign || (BOUNDS_EN && oob);
    end

    // Request fields kept for the RD/WR phases; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            sign_q  <= req_signed;
            wdata_q <= req_wdata[15:0];
        end
    end

    lsu_lane_align u_align (
        .rword     (readData),
        .lane      (lane_q),
        .size      (size_q),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Access sequencer with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            address    <= '0;
            writeData  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready  <= 1'b0;
                        address    <= {req_addr[31:2], 2'b00};
                        resp_rdata <= '0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            state      <= ST_RESP;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            writeData <= req_wdata;
                            memWrite  <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            // Loads and sub-word stores both need the word first.
                            memRead <= 1'b1;
                            cnt     <= CNT_W'(WAIT_CYCLES);
                            state   <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        memRead <= 1'b0;
                        if (write_q) begin
                            writeData <= merged;
                            memWrite  <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            resp_rdata <= load_data;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR: begin
                    memWrite   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (WAIT_CYCLES 0 and 3), each with
// its own word memory, checked against a byte-level reference model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_error [2];
    logic        memRead    [2];
    logic        memWrite   [2];
    logic [31:0] address    [2];
    logic [31:0] writeData  [2];
    logic [31:0] readData   [2];

    logic [31:0] mem [2][1024];
    logic        poke_en   [2];
    logic [31:0] poke_addr [2];
    logic [31:0] poke_data [2];

    logic [7:0]  ref_mem [2][4096];

    int n_cmp;
    int n_bad;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_unit #(
            .WAIT_CYCLES ((g == 0) ? 0 : 3),
            .MEM_BYTES   (4096)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_size   (req_size[g]),
            .req_signed (req_signed[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_error (resp_error[g]),
            .memRead    (memRead[g]),
            .memWrite   (memWrite[g]),
            .address    (address[g]),
            .writeData  (writeData[g]),
            .readData   (readData[g])
        );
        assign readData[g] = mem[g][address[g][11:2]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: aliases on the low 12 address bits; bench preloads via poke.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (memWrite[g]) mem[g][address[g][11:2]] <= writeData[g];
            if (poke_en[g]) mem[g][poke_addr[g][11:2]] <= poke_data[g];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        if (sz == 2'd3) return 1'b1;
        nb = nbytes_of(sz);
        if ((a % nb) != 0) return 1'b1;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
        if (longint'(a) + longint'(nb) > 64'd4096) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                               input int nb, input bit sg);
        longint v;
        int     idx;
        v = 0;
        for (int i = 0; i < nb; i++) begin
            idx = int'((a + 32'(i)) & 32'hFFF);
            v = v + (longint'(ref_mem[d][idx]) << (8 * i));
        end
        if (sg && (v >= (longint'(1) << (8 * nb - 1)))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
        int base;
        base = int'(a & 32'hFFC);
        return {ref_mem[d][base + 3], ref_mem[d][base + 2], ref_mem[d][base + 1], ref_mem[d][base]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic poke(input int d, input logic [31:0] a, input logic [31:0] v);
        int base;
        @(negedge clk);
        poke_en[d]   = 1'b1;
        poke_addr[d] = a;
        poke_data[d] = v;
        @(posedge clk);
        #1;
        poke_en[d] = 1'b0;
        base = int'(a & 32'hFFC);
        for (int i = 0; i < 4; i++) ref_mem[d][base + i] = v[8 * i +: 8];
    endtask

    task automatic init_mem();
        logic [31:0] v0;
        logic [31:0] v1;
        for (int w = 0; w < 1024; w++) begin
            v0 = $urandom;
            v1 = $urandom;
            @(negedge clk);
            poke_en[0] = 1'b1; poke_addr[0] = 32'(w * 4); poke_data[0] = v0;
            poke_en[1] = 1'b1; poke_addr[1] = 32'(w * 4); poke_data[1] = v1;
            @(posedge clk);
            #1;
            poke_en[0] = 1'b0;
            poke_en[1] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ref_mem[0][w * 4 + i] = v0[8 * i +: 8];
                ref_mem[1][w * 4 + i] = v1[8 * i +: 8];
            end
        end
    endtask

    // One transaction: drive, measure latency/strobes, check the response,
    // optionally hold the response with a competing request, then complete.
    task automatic run_txn(input string tag, input int d, input bit wr, input logic [1:0] sz,
                           input bit sg, input logic [31:0] a, input logic [31:0] wd,
                           input bit rr_pre, input int hold, output logic [31:0] got);
        int          w;
        int          nb;
        bit          e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_rdc;
        int          e_wrc;
        int          cycles;
        int          rdc;
        int          wrc;
        bit          addr_bad;
        bit          hold_bad;
        logic [31:0] h_rdata;
        logic        h_err;
        w       = (d == 0) ? 0 : 3;
        nb      = nbytes_of(sz);
        e_err   = model_err(sz, a);
        e_rdata = (!e_err && !wr) ? model_load(d, a, nb, sg) : 32'd0;
        if (e_err)                  begin e_lat = 1;     e_rdc = 0;     e_wrc = 0; end
        else if (!wr)               begin e_lat = 2 + w; e_rdc = 1 + w; e_wrc = 0; end
        else if (sz == 2'd2)        begin e_lat = 2;     e_rdc = 0;     e_wrc = 1; end
        else                        begin e_lat = 3 + w; e_rdc = 1 + w; e_wrc = 1; end

        @(negedge clk);
        n_cmp++;
        if (req_ready[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before d=%0d got=%b want=1", tag, d, req_ready[d]);
        end
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_valid[d]  = 1'b1;
        resp_ready[d] = rr_pre;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        cycles = 1; rdc = 0; wrc = 0; addr_bad = 1'b0;
        while (resp_valid[d] !== 1'b1 && cycles < 40) begin
            if (memRead[d] === 1'b1) rdc++;
            if (memWrite[d] === 1'b1) wrc++;
            if ((memRead[d] === 1'b1 || memWrite[d] === 1'b1) &&
                address[d] !== {a[31:2], 2'b00}) addr_bad = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
        n_cmp++;
        if (cycles != e_lat) begin
            n_bad++;
            $display("FAIL %s latency d=%0d addr=%h got=%0d want=%0d", tag, d, a, cycles, e_lat);
        end
        n_cmp++;
        if (rdc != e_rdc) begin
            n_bad++;
            $display("FAIL %s memRead_cycles d=%0d addr=%h got=%0d want=%0d", tag, d, a, rdc, e_rdc);
        end
        n_cmp++;
        if (wrc != e_wrc) begin
            n_bad++;
            $display("FAIL %s memWrite_cycles d=%0d addr=%h got=%0d want=%0d", tag, d, a, wrc, e_wrc);
        end
        n_cmp++;
        if (addr_bad) begin
            n_bad++;
            $display("FAIL %s address d=%0d got=%h want=%h", tag, d, address[d], {a[31:2], 2'b00});
        end
        got = resp_rdata[d];
        n_cmp++;
        if (resp_rdata[d] !== e_rdata) begin
            n_bad++;
            $display("FAIL %s rdata d=%0d addr=%h got=%h want=%h", tag, d, a, resp_rdata[d], e_rdata);
        end
        n_cmp++;
        if (resp_error[d] !== e_err) begin
            n_bad++;
            $display("FAIL %s error d=%0d addr=%h sz=%0d got=%b want=%b", tag, d, a, sz, resp_error[d], e_err);
        end

        if (!rr_pre && hold > 0) begin
            h_rdata  = resp_rdata[d];
            h_err    = resp_error[d];
            hold_bad = 1'b0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                req_write[d] = 1'b1; req_size[d] = 2'd2; req_addr[d] = 32'd0;
                req_wdata[d] = 32'h1234_5678; req_valid[d] = 1'b1;
                @(posedge clk);
                #1;
                if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== h_rdata || resp_error[d] !== h_err ||
                    req_ready[d] !== 1'b0 || memWrite[d] !== 1'b0 || memRead[d] !== 1'b0)
                    hold_bad = 1'b1;
            end
            n_cmp++;
            if (hold_bad) begin
                n_bad++;
                $display("FAIL %s hold_stable d=%0d got rv=%b rd=%h rdy=%b want rv=1 rd=%h rdy=0",
                         tag, d, resp_valid[d], resp_rdata[d], req_ready[d], h_rdata);
            end
        end
        if (!rr_pre) begin
            @(negedge clk);
            req_valid[d]  = 1'b0;
            resp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        n_cmp++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s complete d=%0d got rv=%b rdy=%b want rv=0 rdy=1", tag, d, resp_valid[d], req_ready[d]);
        end

        if (wr && !e_err) begin
            for (int i = 0; i < nb; i++) ref_mem[d][int'((a + 32'(i)) & 32'hFFF)] = wd[8 * i +: 8];
        end
        if (wr) begin
            n_cmp++;
            if (mem[d][a[11:2]] !== model_word(d, a)) begin
                n_bad++;
                $display("FAIL %s mem_word d=%0d addr=%h got=%h want=%h", tag, d, a, mem[d][a[11:2]], model_word(d, a));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (req_ready[d] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready d=%0d got=%b want=1", d, req_ready[d]);
            end
            n_cmp++;
            if ({resp_valid[d], resp_error[d], memRead[d], memWrite[d], resp_rdata[d], address[d], writeData[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs d=%0d got rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want all 0",
                         d, resp_valid[d], resp_error[d], memRead[d], memWrite[d], resp_rdata[d], address[d], writeData[d]);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] got;
        poke(0, 32'd1000, 32'd10);
        run_txn("load_word", 0, 1'b0, 2'd2, 1'b0, 32'd1000, 32'd0, 1'b1, 0, got);
        n_cmp++;
        if (got !== 32'd10) begin
            n_bad++;
            $display("FAIL load_word_const got=%h want=%h", got, 32'd10);
        end
        poke(0, 32'd1052, 32'd15);
        run_txn("store_byte", 0, 1'b1, 2'd0, 1'b0, 32'd1053, 32'h0000_00FF, 1'b1, 0, got);
        run_txn("load_sbyte", 0, 1'b0, 2'd0, 1'b1, 32'd1053, 32'd0, 1'b1, 0, got);
        n_cmp++;
        if (got !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL load_sbyte_const got=%h want=FFFFFFFF", got);
        end
        run_txn("load_word2", 0, 1'b0, 2'd2, 1'b0, 32'd1052, 32'd0, 1'b0, 0, got);
        n_cmp++;
        if (got !== 32'h0000_FF0F) begin
            n_bad++;
            $display("FAIL load_word2_const got=%h want=0000FF0F", got);
        end
        run_txn("err_half", 0, 1'b0, 2'd1, 1'b0, 32'd1001, 32'd0, 1'b1, 0, got);
        run_txn("err_word", 0, 1'b0, 2'd2, 1'b0, 32'd1002, 32'd0, 1'b1, 0, got);
        run_txn("err_rsvd", 0, 1'b1, 2'd3, 1'b0, 32'd1000, 32'hAAAA_AAAA, 1'b0, 0, got);
        run_txn("err_top", 0, 1'b0, 2'd2, 1'b0, 32'd4094, 32'd0, 1'b1, 0, got);
        run_txn("half_top", 0, 1'b0, 2'd1, 1'b1, 32'd4094, 32'd0, 1'b1, 0, got);
    endtask

    task automatic test_wait_cycles();
        logic [31:0] got;
        poke(1, 32'd1000, 32'h8001_0000);
        run_txn("wait_half", 1, 1'b0, 2'd1, 1'b0, 32'd1002, 32'd0, 1'b1, 0, got);
        n_cmp++;
        if (got !== 32'h0000_8001) begin
            n_bad++;
            $display("FAIL wait_half_const got=%h want=00008001", got);
        end
        run_txn("wait_sh_store", 1, 1'b1, 2'd1, 1'b0, 32'd1000, 32'hCAFE_BEEF, 1'b0, 2, got);
    endtask

    task automatic test_backpressure();
        logic [31:0] got;
        run_txn("bp_load", 0, 1'b0, 2'd2, 1'b0, 32'd1000, 32'd0, 1'b0, 5, got);
        n_cmp++;
        if (mem[0][0] !== model_word(0, 32'd0)) begin
            n_bad++;
            $display("FAIL bp_ignored_req got=%h want=%h", mem[0][0], model_word(0, 32'd0));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        for (int i = 0; i < 6; i++) begin
            run_txn("b2b", 0, 1'(i % 2), 2'(i % 3), 1'b1, 32'd2000 + 32'(i * 4), $urandom, 1'b1, 0, got);
        end
    endtask

    task automatic test_reset_mid();
        poke(0, 32'd1004, 32'd10);
        @(negedge clk);
        req_write[0] = 1'b1; req_size[0] = 2'd2; req_signed[0] = 1'b0;
        req_addr[0] = 32'd1004; req_wdata[0] = 32'hDEAD_BEEF; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n_cmp++;
        if (memWrite[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_wr_cycle got=%b want=1", memWrite[0]);
        end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (memWrite[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_memWrite_drop got=%b want=0", memWrite[0]);
        end
        test_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem[0][251] !== 32'd10) begin
            n_bad++;
            $display("FAIL rstmid_mem got=%h want=%h", mem[0][251], 32'd10);
        end
        n_cmp++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_no_resp got rv=%b rdy=%b want rv=0 rdy=1", resp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        int          d;
        int          r;
        bit          rr;
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 7));
            sz = (r < 7) ? 2'(r % 3) : 2'd3;
            a  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes_of(sz) - 1);
            if ($urandom_range(0, 15) == 0) a = 32'd4096 - 32'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
            rr = 1'($urandom_range(0, 1));
            run_txn("rand", d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                    $urandom, rr, rr ? 0 : int'($urandom_range(0, 2)), got);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0; req_signed[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
            poke_en[d] = 1'b0; poke_addr[d] = 32'd0; poke_data[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        init_mem();
        test_directed();
        test_wait_cycles();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: the load/store controller between the datapath and the byte-addressed data memory.
- Accepts one load or store request at a time from the core over a valid/ready handshake.
- Drives memRead/memWrite/address/writeData to the memory and performs read-modify-write for sub-word stores.
- Returns load data sign- or zero-extended, or an error response, over a valid/ready response channel.

Parameters:
- WAIT_CYCLES, 0: extra cycles memRead is held before readData is sampled (0..15).
- MEM_BYTES, 4096: size of the memory's byte address space; used by the bounds check.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_signed  in  1  load extension: 1 sign, 0 zero
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_error  out  1  misaligned access, reserved size, or out-of-bounds access
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable; memory writes on posedge while high
- address  out  32  word-aligned byte address to memory
- writeData  out  32  word to memory, little-endian lanes
- readData  in  32  combinational memory read data

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all outputs 0 except req_ready=1.
  - memWrite drops immediately, so an in-flight write cycle is aborted with no memory update.
- All memory-side outputs are registered.
- address = {req_addr[31:2],2'b00}, latched at accept.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. Accept on the edge where req_valid&&req_ready. Next state:
  - RESP with resp_error=1 and no strobes, if:
    - req_size==3, or
    - half with addr[0]!=0, or
    - word with addr[1:0]!=0, or
    - out of bounds (see Optional Feature).
  - RD for a load or a sub-word store.
  - WR for a word store, with writeData=req_wdata.
- RD:
  - memRead=1 for 1+WAIT_CYCLES cycles; readData is captured on the final edge.
  - Load: extract the lane and extend, then go to RESP.
  - Sub-word store: merge req_wdata into the captured word, go to WR with memRead=0 and writeData=merged word.
- WR: memWrite=1 for exactly one cycle, then RESP.
- RESP:
  - resp_valid=1 with resp_rdata/resp_error held stable until resp_ready=1, then IDLE.
  - req_ready=0 in every state except IDLE.
- Lane rules (little-endian):
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extension fills bits above the lane with the lane MSB (signed) or 0.
- Latency from the accept edge N, WAIT_CYCLES=W:
  - Error: resp_valid in cycle N+1.
  - Load / word store: N+2+W (word store does not depend on W, so it is N+2).
  - Sub-word store: N+3+W.
- Simultaneous events:
  - req_valid during a busy state is ignored (not queued).
  - If resp_ready is already 1 when RESP is entered, the response completes in one cycle and the next request can be accepted the following cycle.
- Mid-operation reset: returns to IDLE with no response; a partially completed RMW leaves memory unchanged.

Optional Feature:
- Macro MEM_ACCESS_BOUNDS_CHECK_EN.
- Defined: req_addr+access_bytes > MEM_BYTES is an error (resp_error=1, no strobes).
- Undefined: no bounds error; address is passed through and the memory aliases it on its low 12 bits.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - the state enum;
  - the WAIT_CYCLES counter width constant (4);
  - lane extract/extend and merge functions.
- One sub-module is natural: lsu_lane_align, combinational, doing load extraction/extension and store merge.

Test Plan:
- Preload word 10 at 1000, W=0; load word from 1000 -> resp_valid cycle N+2, resp_rdata=10, memRead high exactly 1 cycle.
- Store byte 0xFF to 1053 (word 1052 = 15), then load signed byte 1053 and load word 1052 -> memRead then memWrite, -> rdata 0xFFFFFFFF, then word 0x0000FF0F.
- Load half from 1001 and word from 1002; size=3 -> resp_error=1 at N+1, memRead/memWrite never asserted, rdata 0.
- W=3, load unsigned half from 1002 of word 0x80010000 -> memRead held 4 cycles, resp at N+5, rdata 0x00008001.
- resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, second req_valid ignored.
- Assert rst during the WR cycle of a word store of 0xDEADBEEF to 1004 -> memWrite falls immediately, word 1004 still 10, outputs at reset values; with MEM_ACCESS_BOUNDS_CHECK_EN, word load from 4094 -> resp_error=1.
